// File: rtl/lcd_fade_sequencer.sv
// AHB-Lite master that fades LCD brightness over a number of frames: it programs
// BR_MODE/BR_VALUE, pulses START, counts frame beats, waits a gap, then steps the value.
module lcd_fade_sequencer #(
    parameter int                W_ADDR      = 32,
    parameter int                W_DATA      = 32,
    parameter logic [W_ADDR-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_BEATS = 196609,
    parameter int                W_BEAT      = 20,
    parameter int                GAP_CYC     = 16,
    parameter int                TIMEOUT_CYC = 1000000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_go,
    input  logic              i_mode,
    input  logic [7:0]        i_value_init,
    input  logic [7:0]        i_step,
    input  logic [7:0]        i_n_frames,
    input  logic              i_frame_valid,
    output logic [1:0]        m_HTRANS,
    output logic [W_ADDR-1:0] m_HADDR,
    output logic              m_HWRITE,
    output logic [2:0]        m_HSIZE,
    output logic [2:0]        m_HBURST,
    output logic [W_DATA-1:0] m_HWDATA,
    input  logic              m_HREADY,
    input  logic [1:0]        m_HRESP,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [7:0]        o_frame_idx,
    output logic [2:0]        o_state
);

    // Handshake: an address phase (NONSEQ) and a data phase each complete on the first
    // cycle m_HREADY is 1; until then every bus output is held unchanged.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_ADDR    = 3'd1,
        S_WR_DATA    = 3'd2,
        S_WAIT_FRAME = 3'd3,
        S_GAP        = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam logic [W_BEAT-1:0] BEAT_LAST = W_BEAT'(FRAME_BEATS - 1);
    localparam logic [23:0]       TMO_LAST  = 24'(TIMEOUT_CYC - 1);
    localparam logic [23:0]       GAP_LAST  = 24'(GAP_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mode;
    logic [7:0]        r_value;
    logic [7:0]        r_step;
    logic [7:0]        r_n_frames;
    logic [7:0]        r_frame_idx;
    logic [1:0]        r_wr_idx;
    logic [W_BEAT-1:0] r_beat_cnt;
    logic [23:0]       r_tmo_cnt;
    logic              r_err;

    logic       w_frame_end;
    logic       w_timeout;
    logic       w_gap_end;
    logic       w_more_frames;
    logic       w_wr_err;
    logic [3:0] w_reg;
    logic [7:0] w_wdata;
    logic [8:0] w_value_sum;

    always_comb begin
        w_reg   = 4'd8;
        w_wdata = 8'd0;
        case (r_wr_idx)
            2'd0: begin w_reg = 4'd9;  w_wdata = {7'd0, r_mode}; end
            2'd1: begin w_reg = 4'd10; w_wdata = r_value;        end
            2'd2: begin w_reg = 4'd8;  w_wdata = 8'd1;           end
            default: begin w_reg = 4'd8; w_wdata = 8'd0;        end
        endcase
    end

    assign w_frame_end   = i_frame_valid && (r_beat_cnt == BEAT_LAST);
    assign w_timeout     = (r_tmo_cnt == TMO_LAST);
    assign w_gap_end     = (r_tmo_cnt == GAP_LAST);
    assign w_more_frames = ({1'b0, r_frame_idx} + 9'd1) < {1'b0, r_n_frames};
    assign w_value_sum   = {1'b0, r_value} + {1'b0, r_step};
    assign w_wr_err      = (m_HRESP != 2'b00);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (i_go) w_state_nxt = S_WR_ADDR;
            S_WR_ADDR:    if (m_HREADY) w_state_nxt = S_WR_DATA;
            S_WR_DATA: begin
                if (w_wr_err)      w_state_nxt = S_IDLE;
                else if (m_HREADY) w_state_nxt = (r_wr_idx == 2'd3) ? S_WAIT_FRAME : S_WR_ADDR;
            end
            S_WAIT_FRAME: begin
                if (w_frame_end)    w_state_nxt = S_GAP;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_GAP:        if (w_gap_end) w_state_nxt = w_more_frames ? S_WR_ADDR : S_DONE;
            S_DONE:       w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // r_tmo_cnt doubles as the gap counter; both uses start from zero on state entry.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_mode      <= 1'b0;
            r_value     <= 8'd0;
            r_step      <= 8'd0;
            r_n_frames  <= 8'd0;
            r_frame_idx <= 8'd0;
            r_wr_idx    <= 2'd0;
            r_beat_cnt  <= '0;
            r_tmo_cnt   <= 24'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_go) begin
                    r_mode      <= i_mode;
                    r_value     <= i_value_init;
                    r_step      <= i_step;
                    r_n_frames  <= (i_n_frames == 8'd0) ? 8'd1 : i_n_frames;
                    r_frame_idx <= 8'd0;
                    r_wr_idx    <= 2'd0;
                    r_err       <= 1'b0;
                end
                S_WR_DATA: begin
                    if (w_wr_err) begin
                        r_err <= 1'b1;
                    end else if (m_HREADY) begin
                        r_wr_idx <= r_wr_idx + 2'd1;
                        if (r_wr_idx == 2'd3) begin
                            r_beat_cnt <= '0;
                            r_tmo_cnt  <= 24'd0;
                        end
                    end
                end
                S_WAIT_FRAME: begin
                    if (i_frame_valid) r_beat_cnt <= r_beat_cnt + W_BEAT'(1);
                    r_tmo_cnt <= w_frame_end ? 24'd0 : r_tmo_cnt + 24'd1;
                    if (!w_frame_end && w_timeout) r_err <= 1'b1;
                end
                S_GAP: begin
                    r_tmo_cnt <= r_tmo_cnt + 24'd1;
                    if (w_gap_end && w_more_frames) begin
                        r_frame_idx <= r_frame_idx + 8'd1;
                        r_value     <= w_value_sum[8] ? 8'hFF : w_value_sum[7:0];
                        r_wr_idx    <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_HTRANS    = (r_state == S_WR_ADDR) ? 2'b10 : 2'b00;
    assign m_HADDR     = (r_state == S_WR_ADDR) ? BASE_ADDR + W_ADDR'({w_reg, 2'b00}) : '0;
    assign m_HWRITE    = (r_state == S_WR_ADDR);
    assign m_HSIZE     = (r_state == S_WR_ADDR) ? 3'b010 : 3'b000;
    assign m_HBURST    = 3'b000;
    assign m_HWDATA    = (r_state == S_WR_DATA) ? W_DATA'(w_wdata) : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = r_err;
    assign o_frame_idx = r_frame_idx;
    assign o_state     = r_state;

endmodule

// File: tb/tb_lcd_fade_sequencer.sv
// Directed bench for lcd_fade_sequencer: an AHB slave model with wait states and error
// injection, and a queue of expected {frame_idx, addr, data} writes.
module tb_lcd_fade_sequencer;

    localparam int          FB   = 10;
    localparam int          GAP  = 4;
    localparam int          TMO  = 60;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        i_go = 1'b0;
    logic        i_mode = 1'b0;
    logic [7:0]  i_value_init = 8'd0;
    logic [7:0]  i_step = 8'd0;
    logic [7:0]  i_n_frames = 8'd0;
    logic        i_frame_valid = 1'b0;
    logic        m_HREADY = 1'b1;
    logic [1:0]  m_HRESP = 2'b00;
    logic [1:0]  m_HTRANS;
    logic [31:0] m_HADDR;
    logic        m_HWRITE;
    logic [2:0]  m_HSIZE;
    logic [2:0]  m_HBURST;
    logic [31:0] m_HWDATA;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_frame_idx;
    logic [2:0]  o_state;

    lcd_fade_sequencer #(
        .W_ADDR(32), .W_DATA(32), .BASE_ADDR(BASE), .FRAME_BEATS(FB),
        .W_BEAT(20), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .i_go(i_go), .i_mode(i_mode),
        .i_value_init(i_value_init), .i_step(i_step), .i_n_frames(i_n_frames),
        .i_frame_valid(i_frame_valid), .m_HTRANS(m_HTRANS), .m_HADDR(m_HADDR),
        .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HWDATA(m_HWDATA),
        .m_HREADY(m_HREADY), .m_HRESP(m_HRESP), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_frame_idx(o_frame_idx), .o_state(o_state)
    );

    // Clock / reset
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [71:0] exp_q[$];
    int          ws = 0;
    int          err_at = -1;
    int          wr_num = 0;
    int          done_cnt = 0;
    int          ns_cnt = 0;
    int          wcnt = 0;
    bit          fv_en = 1'b0;
    bit          dphase = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [65:0] held = '0;
    int          ns_snap;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    // Driver tasks
    task automatic push_write(input logic [7:0] f, input logic [3:0] r, input logic [7:0] d);
        exp_q.push_back({f, BASE + {26'd0, r, 2'b00}, 24'd0, d});
    endtask

    task automatic push_run(input logic m, input logic [7:0] init, input logic [7:0] step,
                            input logic [7:0] n);
        int nn;
        int v;
        nn = (n == 8'd0) ? 1 : int'(n);
        v  = int'(init);
        for (int f = 0; f < nn; f++) begin
            push_write(8'(f), 4'd9, {7'd0, m});
            push_write(8'(f), 4'd10, 8'(v));
            push_write(8'(f), 4'd8, 8'd1);
            push_write(8'(f), 4'd8, 8'd0);
            v = v + int'(step);
            if (v > 255) v = 255;
        end
    endtask

    task automatic start_run(input logic m, input logic [7:0] init, input logic [7:0] step,
                             input logic [7:0] n);
        i_mode = m;
        i_value_init = init;
        i_step = step;
        i_n_frames = n;
        wr_num = 0;
        done_cnt = 0;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, o_busy, 1'b0);
    endtask

    task automatic wait_q_empty(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, m_HTRANS, 2'b00);
        check({tag, "_haddr"}, m_HADDR, 32'd0);
        check({tag, "_hwdata"}, m_HWDATA, 32'd0);
        check({tag, "_hwrite"}, m_HWRITE, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
        check({tag, "_frame_idx"}, o_frame_idx, 8'd0);
    endtask

    // Slave model and scoreboard: responds at the falling edge, compares completed writes.
    always @(negedge HCLK) begin
        i_frame_valid = fv_en ? ($urandom_range(0, 3) != 0) : 1'b0;
        if (o_done) done_cnt++;
        if (!HRESETn) begin
            dphase = 1'b0;
            hold = 1'b0;
            wcnt = 0;
            m_HREADY = 1'b1;
            m_HRESP = 2'b00;
        end else begin
            if (hold) check("hold_stable", {m_HTRANS, m_HADDR, m_HWDATA}, held);
            if (m_HTRANS == 2'b10 || dphase) begin
                if (dphase && wr_num == err_at) begin
                    m_HREADY = 1'b1;
                    m_HRESP = 2'b01;
                end else begin
                    m_HRESP = 2'b00;
                    if (wcnt < ws) begin
                        m_HREADY = 1'b0;
                        wcnt++;
                    end else begin
                        m_HREADY = 1'b1;
                        wcnt = 0;
                    end
                end
                hold = !m_HREADY;
                held = {m_HTRANS, m_HADDR, m_HWDATA};
                if (m_HREADY) begin
                    if (dphase) begin
                        if (m_HRESP == 2'b00) begin
                            if (exp_q.size() == 0)
                                check("unexpected_write", {o_frame_idx, d_addr, m_HWDATA}, 72'd0);
                            else
                                check("write", {o_frame_idx, d_addr, m_HWDATA}, exp_q.pop_front());
                        end
                        wr_num++;
                        dphase = 1'b0;
                    end else begin
                        dphase = 1'b1;
                        d_addr = m_HADDR;
                        ns_cnt++;
                    end
                end
            end else begin
                m_HREADY = 1'b1;
                m_HRESP = 2'b00;
                hold = 1'b0;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        HRESETn = 1'b1;
        tick();

        // Single frame, zero-wait slave
        fv_en = 1'b1;
        push_run(1'b0, 8'h20, 8'h00, 8'd1);
        start_run(1'b0, 8'h20, 8'h00, 8'd1);
        check("t1_go_latency", m_HTRANS, 2'b10);
        check("t1_haddr_first", m_HADDR, BASE + 32'd36);
        check("t1_busy", o_busy, 1'b1);
        wait_idle("t1_idle", 200);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_err", o_err, 1'b0);
        check("t1_q_empty", exp_q.size(), 0);

        // n_frames = 0 behaves as a single frame
        push_run(1'b1, 8'h55, 8'h10, 8'd0);
        start_run(1'b1, 8'h55, 8'h10, 8'd0);
        wait_idle("t0_idle", 200);
        check("t0_done_cnt", done_cnt, 1);
        check("t0_q_empty", exp_q.size(), 0);

        // Three frames with saturation; a second i_go while busy must be ignored
        push_run(1'b0, 8'hF0, 8'h0C, 8'd3);
        start_run(1'b0, 8'hF0, 8'h0C, 8'd3);
        repeat (5) tick();
        i_value_init = 8'h11;
        i_n_frames = 8'd9;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        wait_idle("t2_idle", 400);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_frame_idx_final", o_frame_idx, 8'd2);
        check("t2_q_empty", exp_q.size(), 0);

        // Three wait states in both phases
        ws = 3;
        push_run(1'b1, 8'h80, 8'h01, 8'd2);
        start_run(1'b1, 8'h80, 8'h01, 8'd2);
        wait_idle("t3_idle", 600);
        ws = 0;
        check("t3_done_cnt", done_cnt, 1);
        check("t3_q_empty", exp_q.size(), 0);

        // ERROR response on the START=1 write
        err_at = 2;
        push_write(8'd0, 4'd9, 8'd0);
        push_write(8'd0, 4'd10, 8'h42);
        start_run(1'b0, 8'h42, 8'h01, 8'd2);
        wait_idle("t4_idle", 100);
        check("t4_err", o_err, 1'b1);
        check("t4_state_idle", o_state, 3'd0);
        ns_snap = ns_cnt;
        repeat (20) tick();
        check("t4_no_more_nonseq", ns_cnt, ns_snap);
        check("t4_no_done", done_cnt, 0);
        check("t4_q_empty", exp_q.size(), 0);
        err_at = -1;

        // Frame never arrives: timeout, then a new run clears the error
        fv_en = 1'b0;
        push_run(1'b0, 8'h10, 8'h00, 8'd1);
        start_run(1'b0, 8'h10, 8'h00, 8'd1);
        wait_q_empty("t5_writes", 60);
        repeat (TMO - 10) tick();
        check("t5_busy_before_tmo", o_busy, 1'b1);
        check("t5_err_before_tmo", o_err, 1'b0);
        wait_idle("t5_idle", 100);
        check("t5_err", o_err, 1'b1);
        check("t5_no_done", done_cnt, 0);
        fv_en = 1'b1;
        push_run(1'b0, 8'h33, 8'h00, 8'd1);
        start_run(1'b0, 8'h33, 8'h00, 8'd1);
        check("t5_err_cleared", o_err, 1'b0);
        wait_idle("t5b_idle", 200);
        check("t5b_done_cnt", done_cnt, 1);
        check("t5b_q_empty", exp_q.size(), 0);

        // Reset pulse during WAIT_FRAME, then a fresh run from frame 0
        fv_en = 1'b0;
        push_run(1'b0, 8'h44, 8'h00, 8'd1);
        start_run(1'b0, 8'h44, 8'h00, 8'd1);
        wait_q_empty("t6_writes", 60);
        repeat (5) tick();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        check_reset_outputs("t6_rst");
        fv_en = 1'b1;
        push_run(1'b1, 8'h90, 8'h20, 8'd2);
        start_run(1'b1, 8'h90, 8'h20, 8'd2);
        check("t6_restart_frame0", o_frame_idx, 8'd0);
        wait_idle("t6_idle", 300);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_q_empty", exp_q.size(), 0);

        // Final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
